min_display: RTL and testbench

Display back-end for the minute counter: reads the 16-bit binary minute value and the minute-tick strobe, converts the value to two BCD digits with a sequential shift-add-3 (double-dabble) engine, and drives two DE10-Lite seven-segment digits (HEX1 tens, HEX0 units). It sits between the minute counter and the board display pins and re-converts automatically whenever the minute value changes.

---
 rtl/min_display_if.sv | 20 ++
 rtl/min_display.sv | 148 ++++++++++++++
 tb/tb_min_display.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/min_display_if.sv
// Bus between the minute counter / board pins and the minute display back-end.
// The counter side drives min/min_tick; the display side drives the segments and status.
interface min_display_if;
  logic [15:0] min;
  logic        min_tick;
  logic [7:0]  HEX0;
  logic [7:0]  HEX1;
  logic        busy;
  logic        ovf;

  modport master (
    output min, min_tick,
    input  HEX0, HEX1, busy, ovf
  );

  modport slave (
    input  min, min_tick,
    output HEX0, HEX1, busy, ovf
  );
endinterface

// File: rtl/min_display.sv
// Minute display: double-dabble conversion of the 16-bit minute value to BCD,
// driving HEX1 (tens) / HEX0 (units) with a min_tick-driven blinking dp on HEX1.
module min_display #(
  parameter bit LEADING_BLANK = 1'b0,
  parameter bit TICK_DP       = 1'b1
) (
  input  logic          MAX10_CLK1_50,
  input  logic          reset,
  min_display_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam logic [6:0] SEG_ZERO  = 7'h40;
  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  state_t      state_q, state_d;
  logic [15:0] last_q, last_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        busy_q, busy_d;
  logic        ovf_q, ovf_d;
  logic [6:0]  seg0_q, seg0_d;
  logic [6:0]  seg1_q, seg1_d;
  logic        dp_q, dp_d;
  logic        tick_q, tick_prev_q;
  logic [15:0] sr_q, sr_d;
  logic [19:0] bcd_q, bcd_d;
  logic [19:0] adj;

  function automatic logic [19:0] add3(input logic [19:0] b);
    logic [19:0] r;
    logic [3:0]  nib;
    r = '0;
    for (int i = 0; i < 5; i++) begin
      nib = b[i*4 +: 4];
      if (nib >= 4'd5) nib = nib + 4'd3;
      r[i*4 +: 4] = nib;
    end
    return r;
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0: s = 7'h40;
      4'd1: s = 7'h79;
      4'd2: s = 7'h24;
      4'd3: s = 7'h30;
      4'd4: s = 7'h19;
      4'd5: s = 7'h12;
      4'd6: s = 7'h02;
      4'd7: s = 7'h78;
      4'd8: s = 7'h00;
      4'd9: s = 7'h10;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    ovf_d   = ovf_q;
    seg0_d  = seg0_q;
    seg1_d  = seg1_q;
    sr_d    = sr_q;
    bcd_d   = bcd_q;
    adj     = '0;
    case (state_q)
      IDLE: begin
        if (bus.min != last_q) begin
          sr_d    = bus.min;
          bcd_d   = '0;
          last_d  = bus.min;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        adj   = add3(bcd_q);
        bcd_d = {adj[18:0], sr_q[15]};
        sr_d  = {sr_q[14:0], 1'b0};
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd15) state_d = DONE;
      end
      DONE: begin
        ovf_d = |bcd_q[19:8];
        if (|bcd_q[19:8]) begin
          seg0_d = SEG_DASH;
          seg1_d = SEG_DASH;
        end else begin
          seg0_d = seg7(bcd_q[3:0]);
          seg1_d = (LEADING_BLANK && (bcd_q[7:4] == 4'd0)) ? SEG_BLANK : seg7(bcd_q[7:4]);
        end
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // dp runs off its own edge detector, so it keeps blinking during a conversion
  always_comb begin
    dp_d = TICK_DP ? (dp_q ^ (tick_q & ~tick_prev_q)) : 1'b1;
  end

  always_ff @(posedge MAX10_CLK1_50 or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      last_q      <= '0;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      ovf_q       <= 1'b0;
      seg0_q      <= SEG_ZERO;
      seg1_q      <= SEG_ZERO;
      dp_q        <= 1'b1;
      tick_q      <= 1'b0;
      tick_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
      busy_q      <= busy_d;
      ovf_q       <= ovf_d;
      seg0_q      <= seg0_d;
      seg1_q      <= seg1_d;
      dp_q        <= dp_d;
      tick_q      <= bus.min_tick;
      tick_prev_q <= tick_q;
    end
  end

  // Conversion datapath is always loaded in IDLE before use, so it needs no reset
  always_ff @(posedge MAX10_CLK1_50) begin
    sr_q  <= sr_d;
    bcd_q <= bcd_d;
  end

  assign bus.HEX0 = {1'b1, seg0_q};
  assign bus.HEX1 = {dp_q, seg1_q};
  assign bus.busy = busy_q;
  assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_min_display.sv
// Directed bench for min_display: scoreboard of expected digits per conversion,
// two instances (default options, and leading-blank with fixed dp).
module tb_min_display;

  logic clk = 1'b0;
  logic rst;

  min_display_if bus_a ();
  min_display_if bus_b ();

  min_display #(.LEADING_BLANK(1'b0), .TICK_DP(1'b1)) dut_a (
    .MAX10_CLK1_50(clk), .reset(rst), .bus(bus_a.slave)
  );
  min_display #(.LEADING_BLANK(1'b1), .TICK_DP(1'b0)) dut_b (
    .MAX10_CLK1_50(clk), .reset(rst), .bus(bus_b.slave)
  );

  always #10 clk = ~clk;

  typedef struct packed {
    logic [7:0] h1;
    logic [7:0] h0;
    logic       ov;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  int   checks   = 0;
  int   failures = 0;
  logic dp_exp   = 1'b1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] seg(input int d);
    case (d)
      0: return 8'hC0;
      1: return 8'hF9;
      2: return 8'hA4;
      3: return 8'hB0;
      4: return 8'h99;
      5: return 8'h92;
      6: return 8'h82;
      7: return 8'hF8;
      8: return 8'h80;
      default: return 8'h90;
    endcase
  endfunction

  function automatic exp_t model(input int v, input bit lb);
    exp_t e;
    if (v > 99) begin
      e.h1 = 8'hBF; e.h0 = 8'hBF; e.ov = 1'b1;
    end else begin
      e.ov = 1'b0;
      e.h0 = seg(v % 10);
      e.h1 = (lb && (v / 10 == 0)) ? 8'hFF : seg(v / 10);
    end
    return e;
  endfunction

  task automatic set_min(input int v);
    @(negedge clk);
    bus_a.min = 16'(v);
    bus_b.min = 16'(v);
    q_a.push_back(model(v, 1'b0));
    q_b.push_back(model(v, 1'b1));
  endtask

  task automatic wait_conv(input string tag, input int pre);
    int   n;
    bit   seen;
    exp_t ea, eb;
    n    = pre;
    seen = (pre > 0);
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (bus_a.busy) begin
        seen = 1'b1;
        n++;
      end else if (seen) begin
        break;
      end
    end
    chk({tag, "_busy_cycles"}, n, 17);
    if (q_a.size() == 0 || q_b.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL %s_scoreboard: observed=empty expected=entry", tag);
      return;
    end
    ea = q_a.pop_front();
    eb = q_b.pop_front();
    chk({tag, "_hex0_a"}, bus_a.HEX0, ea.h0);
    chk({tag, "_hex1_a"}, bus_a.HEX1, {dp_exp, ea.h1[6:0]});
    chk({tag, "_ovf_a"},  bus_a.ovf,  ea.ov);
    chk({tag, "_hex0_b"}, bus_b.HEX0, eb.h0);
    chk({tag, "_hex1_b"}, bus_b.HEX1, eb.h1);
    chk({tag, "_ovf_b"},  bus_b.ovf,  eb.ov);
    chk({tag, "_busy_b"}, bus_b.busy, 1'b0);
  endtask

  task automatic set_tick(input logic v);
    @(negedge clk);
    bus_a.min_tick = v;
    bus_b.min_tick = v;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    rst = 1'b1;
    bus_a.min = '0; bus_a.min_tick = 1'b0;
    bus_b.min = '0; bus_b.min_tick = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_hex0_a", bus_a.HEX0, 8'hC0);
    chk("rst_hex1_a", bus_a.HEX1, 8'hC0);
    chk("rst_busy_a", bus_a.busy, 1'b0);
    chk("rst_ovf_a",  bus_a.ovf,  1'b0);
    chk("rst_hex1_b", bus_b.HEX1, 8'hC0);
    rst = 1'b0;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus_a.busy || bus_b.busy) n++;
    end
    chk("idle_no_conv", n, 0);
    chk("idle_hex0_a", bus_a.HEX0, 8'hC0);
    chk("idle_hex1_a", bus_a.HEX1, 8'hC0);

    set_min(37);    wait_conv("m37", 0);
    set_min(59);    wait_conv("m59", 0);
    set_min(0);     wait_conv("wrap0", 0);
    set_min(100);   wait_conv("m100", 0);
    set_min(65535); wait_conv("m65535", 0);
    set_min(5);     wait_conv("m5", 0);

    // change during busy: first result is 12, then 45 restarts right after
    set_min(12);
    repeat (4) @(negedge clk);
    set_min(45);
    wait_conv("b2b12", 5);
    @(negedge clk);
    chk("b2b_restart", bus_a.busy, 1'b1);
    wait_conv("b2b45", 1);

    set_tick(1'b1);
    repeat (3) @(negedge clk);
    dp_exp = 1'b0;
    chk("tick1_dp_a", bus_a.HEX1[7], dp_exp);
    chk("tick1_dp_b", bus_b.HEX1[7], 1'b1);
    repeat (97) @(negedge clk);
    chk("tick_held_dp_a", bus_a.HEX1[7], dp_exp);
    set_tick(1'b0);
    repeat (5) @(negedge clk);
    chk("tick_low_dp_a", bus_a.HEX1[7], dp_exp);
    set_tick(1'b1);
    repeat (3) @(negedge clk);
    dp_exp = 1'b1;
    chk("tick2_dp_a", bus_a.HEX1[7], dp_exp);
    chk("tick2_dp_b", bus_b.HEX1[7], 1'b1);
    chk("tick2_digits_a", bus_a.HEX1[6:0], 7'h19);
    set_tick(1'b0);
    repeat (3) @(negedge clk);
    set_tick(1'b1);
    repeat (3) @(negedge clk);
    dp_exp = 1'b0;
    chk("tick3_dp_a", bus_a.HEX1[7], dp_exp);
    set_tick(1'b0);

    // reset in the middle of a conversion
    set_min(77);
    repeat (4) @(negedge clk);
    chk("pre_rst_busy", bus_a.busy, 1'b1);
    rst = 1'b1;
    #1;
    chk("midrst_hex0_a", bus_a.HEX0, 8'hC0);
    chk("midrst_hex1_a", bus_a.HEX1, 8'hC0);
    chk("midrst_busy_a", bus_a.busy, 1'b0);
    chk("midrst_ovf_a",  bus_a.ovf,  1'b0);
    chk("midrst_hex1_b", bus_b.HEX1, 8'hC0);
    q_a.delete();
    q_b.delete();
    dp_exp = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    q_a.push_back(model(77, 1'b0));
    q_b.push_back(model(77, 1'b1));
    wait_conv("rst_resume77", 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
